timer_cnt_ctrl: RTL and testbench

Control block that sequences the 64-bit timer counter. It generates the count_en pulse stream through a 2^N prescaler and runs the IDLE/RUN/HALTED state machine with a debug-halt handshake. It holds the 64-bit compare register, which is written by byte-strobed 32-bit halves, and raises the compare-match interrupt. It sits between the register decode logic and the counter datapath; the counter's cnt output feeds back into this block.

---
 rtl/timer_cnt_ctrl.sv | 144 ++++++++++++++
 tb/tb_timer_cnt_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_cnt_ctrl.sv
// Control block for the 64-bit timer counter.
//
// Purpose:
//   - Runs the IDLE/RUN/HALTED state machine (HALTED only with TIMER_HALT_EN).
//   - Generates count_en through a 2^D prescaler, D = min(div_val, MAX_DIV).
//   - Holds the byte-strobed 64-bit compare register.
//   - Raises the compare-match interrupt.
//
// Optional feature macro: TIMER_HALT_EN
//   - Defined: builds the HALTED state and the halt_req/halt_ack handshake.
//   - Undefined: halt_req is ignored and halt_ack is tied low.
//
// Ports:
//   sys_clk, sys_rst    clock and synchronous active-high reset
//   timer_en            enable from control register
//   div_en, div_val     prescaler enable and exponent
//   halt_req, halt_ack  debug halt request (level) / acknowledge (HALTED)
//   cnt, cnt_wr         counter value fed back / counter write pulse
//   tcmp0_wr_sel        compare low-half write select
//   tcmp1_wr_sel        compare high-half write select
//   wdata, pstrb        write data and byte strobes
//   int_en, int_st_clr  interrupt enable / status clear pulse
//   count_en            increment enable to the counter
//   tcmp                compare register
//   int_st, tim_int     interrupt status / masked interrupt output
module timer_cnt_ctrl #(
  parameter int unsigned MAX_DIV = 8,
  parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        timer_en,
  input  logic        div_en,
  input  logic [3:0]  div_val,
  input  logic        halt_req,
  output logic        halt_ack,
  input  logic [63:0] cnt,
  input  logic        cnt_wr,
  input  logic        tcmp0_wr_sel,
  input  logic        tcmp1_wr_sel,
  input  logic [31:0] wdata,
  input  logic [3:0]  pstrb,
  input  logic        int_en,
  input  logic        int_st_clr,
  output logic        count_en,
  output logic [63:0] tcmp,
  output logic        int_st,
  output logic        tim_int
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e      state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic [7:0]  presc_max;
  logic [3:0]  div_eff;
  logic        div_en_q;
  logic [3:0]  div_val_q;
  logic        presc_clr;
  logic [63:0] tcmp_q, tcmp_d;
  logic        int_st_q, int_st_d;
  logic        match;

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef TIMER_HALT_EN
      StIdle:   state_d = halt_req ? StHalted : (timer_en ? StRun : StIdle);
      StRun:    state_d = halt_req ? StHalted : (timer_en ? StRun : StIdle);
      StHalted: state_d = halt_req ? StHalted : (timer_en ? StRun : StIdle);
`else
      StIdle:   state_d = timer_en ? StRun : StIdle;
      StRun:    state_d = timer_en ? StRun : StIdle;
      StHalted: state_d = StIdle;
`endif
      default:  state_d = StIdle;
    endcase
  end

`ifndef TIMER_HALT_EN
  logic unused_halt_req;
  assign unused_halt_req = halt_req;
`endif

  // Prescaler: terminal value is 2^D - 1 with D clamped to MAX_DIV.
  always_comb begin
    div_eff   = (div_val > 4'(MAX_DIV)) ? 4'(MAX_DIV) : div_val;
    presc_max = 8'((9'd1 << div_eff) - 9'd1);
    presc_clr = cnt_wr | (div_en != div_en_q) | (div_val != div_val_q) |
                (state_d == StIdle);
    if (presc_clr) begin
      presc_d = 8'd0;
    end else if (state_q == StRun) begin
      presc_d = (presc_q == presc_max) ? 8'd0 : 8'(presc_q + 8'd1);
    end else begin
      // HALTED keeps the phase so counting resumes where it stopped.
      presc_d = presc_q;
    end
  end

  // Compare register byte writes; the low half wins when both are selected.
  always_comb begin
    tcmp_d = tcmp_q;
    if (tcmp0_wr_sel) begin
      for (int k = 0; k < 4; k++) begin
        if (pstrb[k]) tcmp_d[8*k +: 8] = wdata[8*k +: 8];
      end
    end else if (tcmp1_wr_sel) begin
      for (int k = 0; k < 4; k++) begin
        if (pstrb[k]) tcmp_d[32+8*k +: 8] = wdata[8*k +: 8];
      end
    end
  end

  // Interrupt status: a match wins over a simultaneous clear.
  always_comb begin
    match    = (cnt == tcmp_q);
    int_st_d = match ? 1'b1 : (int_st_clr ? 1'b0 : int_st_q);
  end

  always_ff @(posedge sys_clk) begin
    div_en_q  <= div_en;
    div_val_q <= div_val;
    if (sys_rst) begin
      state_q  <= StIdle;
      presc_q  <= 8'd0;
      tcmp_q   <= CMP_RST;
      int_st_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      tcmp_q   <= tcmp_d;
      int_st_q <= int_st_d;
    end
  end

  assign count_en = (state_q == StRun) && (!div_en || (presc_q == presc_max));
  assign halt_ack = (state_q == StHalted);
  assign tcmp     = tcmp_q;
  assign int_st   = int_st_q;
  assign tim_int  = int_st_q & int_en;

endmodule

// File: tb/tb_timer_cnt_ctrl.sv
// Directed self-checking bench for timer_cnt_ctrl.
module tb_timer_cnt_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        halt_req;
  logic        halt_ack;
  logic [63:0] cnt;
  logic        cnt_wr;
  logic        tcmp0_wr_sel;
  logic        tcmp1_wr_sel;
  logic [31:0] wdata;
  logic [3:0]  pstrb;
  logic        int_en;
  logic        int_st_clr;
  logic        count_en;
  logic [63:0] tcmp;
  logic        int_st;
  logic        tim_int;

  int n_checks = 0;
  int n_err    = 0;
  int first_pulse;
  int n_pulse;

  always #5 sys_clk = ~sys_clk;

  timer_cnt_ctrl #(
    .MAX_DIV(8),
    .CMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .timer_en    (timer_en),
    .div_en      (div_en),
    .div_val     (div_val),
    .halt_req    (halt_req),
    .halt_ack    (halt_ack),
    .cnt         (cnt),
    .cnt_wr      (cnt_wr),
    .tcmp0_wr_sel(tcmp0_wr_sel),
    .tcmp1_wr_sel(tcmp1_wr_sel),
    .wdata       (wdata),
    .pstrb       (pstrb),
    .int_en      (int_en),
    .int_st_clr  (int_st_clr),
    .count_en    (count_en),
    .tcmp        (tcmp),
    .int_st      (int_st),
    .tim_int     (tim_int)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1'b1; timer_en = 1'b0; div_en = 1'b0; div_val = 4'd0;
    halt_req = 1'b0; cnt = 64'd0; cnt_wr = 1'b0; tcmp0_wr_sel = 1'b0;
    tcmp1_wr_sel = 1'b0; wdata = 32'd0; pstrb = 4'd0; int_en = 1'b0;
    int_st_clr = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_count_en", 64'(count_en), 64'd0);
    chk("rst_halt_ack", 64'(halt_ack), 64'd0);
    chk("rst_tcmp", tcmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_int_st", 64'(int_st), 64'd0);
    chk("rst_tim_int", 64'(tim_int), 64'd0);

    // Undivided counting
    sys_rst = 1'b0; timer_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("nodiv_count_en", 64'(count_en), 64'd1);
      tick();
    end

    // div_val=2: one pulse every 4 cycles
    div_en = 1'b1; div_val = 4'd2;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("div2_count_en", 64'(count_en), 64'((i % 4) == 3));
      tick();
    end

    // div_val=12 clamps to 8: one pulse per 256 cycles
    div_val = 4'd12;
    tick();
    first_pulse = -1; n_pulse = 0;
    for (int i = 0; i < 256; i++) begin
      if (count_en) begin
        n_pulse++;
        if (first_pulse < 0) first_pulse = i;
      end
      tick();
    end
    chk("div12_first_pulse", 64'(first_pulse), 64'd255);
    chk("div12_pulse_count", 64'(n_pulse), 64'd1);

    // Changing div_val mid-run restarts the phase
    div_val = 4'd2;
    tick(); tick();
    div_val = 4'd3;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("divchg_count_en", 64'(count_en), 64'(i == 7));
      tick();
    end

    // cnt_wr mid-prescale restarts the phase
    tick(); tick();
    cnt_wr = 1'b1;
    tick();
    cnt_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("cntwr_count_en", 64'(count_en), 64'(i == 7));
      tick();
    end

    // Compare byte writes
    tcmp0_wr_sel = 1'b1; wdata = 32'h1122_3344; pstrb = 4'b0101;
    tick();
    tcmp0_wr_sel = 1'b0;
    chk("tcmp0_strb", tcmp, 64'hFFFF_FFFF_FF22_FF44);
    tcmp1_wr_sel = 1'b1; wdata = 32'd0; pstrb = 4'hF;
    tick();
    tcmp1_wr_sel = 1'b0;
    chk("tcmp1_full", tcmp, 64'h0000_0000_FF22_FF44);
    tcmp0_wr_sel = 1'b1; tcmp1_wr_sel = 1'b1; wdata = 32'h0000_00AA; pstrb = 4'b0001;
    tick();
    tcmp1_wr_sel = 1'b0;
    chk("tcmp_both_sel", tcmp, 64'h0000_0000_FF22_FFAA);
    wdata = 32'h0000_0010; pstrb = 4'hF;
    tick();
    tcmp0_wr_sel = 1'b0;
    chk("tcmp_0x10", tcmp, 64'h0000_0000_0000_0010);

    // Compare match and interrupt
    int_en = 1'b1; cnt = 64'h0F;
    tick();
    chk("nomatch_int_st", 64'(int_st), 64'd0);
    cnt = 64'h10;
    tick();
    chk("match_int_st", 64'(int_st), 64'd1);
    chk("match_tim_int", 64'(tim_int), 64'd1);
    int_st_clr = 1'b1;
    tick();
    chk("clr_during_match", 64'(int_st), 64'd1);
    cnt = 64'h11;
    tick();
    int_st_clr = 1'b0;
    chk("clr_after_match", 64'(int_st), 64'd0);
    chk("clr_tim_int", 64'(tim_int), 64'd0);
    int_en = 1'b0; cnt = 64'h10;
    tick();
    chk("masked_int_st", 64'(int_st), 64'd1);
    chk("masked_tim_int", 64'(tim_int), 64'd0);
    cnt = 64'h11; int_st_clr = 1'b1;
    tick();
    int_st_clr = 1'b0;
    chk("masked_clr", 64'(int_st), 64'd0);

    // Match at zero after wrap
    tcmp0_wr_sel = 1'b1; wdata = 32'd0; pstrb = 4'hF;
    tick();
    tcmp0_wr_sel = 1'b0;
    chk("tcmp_zero", tcmp, 64'd0);
    cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("allones_no_match", 64'(int_st), 64'd0);
    cnt = 64'd0;
    tick();
    chk("wrap_match", 64'(int_st), 64'd1);
    cnt = 64'd5; int_st_clr = 1'b1;
    tick();
    int_st_clr = 1'b0;
    chk("wrap_clr", 64'(int_st), 64'd0);

    // Halt handshake (div_val=3, divider enabled)
    timer_en = 1'b0;
    tick();
    chk("idle_count_en", 64'(count_en), 64'd0);
    timer_en = 1'b1;
    tick();
    tick(); tick(); tick();
    halt_req = 1'b1;
    tick();
`ifdef TIMER_HALT_EN
    chk("halt_ack_rise", 64'(halt_ack), 64'd1);
    chk("halt_count_en", 64'(count_en), 64'd0);
    tick(); tick(); tick();
    chk("halt_hold_ack", 64'(halt_ack), 64'd1);
    chk("halt_hold_count_en", 64'(count_en), 64'd0);
    halt_req = 1'b0;
    tick();
    chk("halt_ack_fall", 64'(halt_ack), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk("resume_count_en", 64'(count_en), 64'(i == 3));
      tick();
    end
`else
    chk("nohalt_ack", 64'(halt_ack), 64'd0);
    chk("nohalt_count_en", 64'(count_en), 64'd0);
    tick(); tick(); tick();
    chk("nohalt_ack_hold", 64'(halt_ack), 64'd0);
    chk("nohalt_keeps_counting", 64'(count_en), 64'd1);
    halt_req = 1'b0;
    tick();
`endif

    // Reset mid-RUN
    cnt = 64'd0;
    tick();
    chk("pre_rst_int_st", 64'(int_st), 64'd1);
    sys_rst = 1'b1;
    tick();
    chk("midrst_count_en", 64'(count_en), 64'd0);
    chk("midrst_tcmp", tcmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("midrst_int_st", 64'(int_st), 64'd0);
    chk("midrst_halt_ack", 64'(halt_ack), 64'd0);
    sys_rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
